dds_multi_gen: RTL and testbench
================================

DDS_MULTI_GEN -- requirements
Module: dds_multi_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of independent DDS channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 32, meaning phase accumulator width.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning waveform table address width (phase bits used).
REQ-004 SHALL have parameter DATA_W, default 8, meaning output sample width, unsigned offset-binary.
REQ-005 SHALL have parameter FSTEP, default 300, meaning increment/decrement applied by step pulses.
REQ-006 SHALL have port clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port sample_en  in  1  sample-rate strobe; accumulators advance only when high.
REQ-009 SHALL have ports cfg_we in 1, cfg_ch in clog2(N_CH), cfg_sel in 2 (0 fword, 1 pword, 2 mode), and cfg_wdata in ACC_W, forming the shadow-register write port.
REQ-010 SHALL have port cfg_commit  in  1  request to transfer all shadow registers to active registers.
REQ-011 SHALL have ports step_up in N_CH and step_dn in N_CH, single-cycle per-channel frequency step pulses.
REQ-012 SHALL have port ph_clr  in  N_CH  per-channel synchronous accumulator clear.
REQ-013 SHALL have port wave_out  out  N_CH*DATA_W  samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have ports wave_valid out 1 (one-cycle pulse marking new samples) and wrap out N_CH (accumulator-overflow pulses).
REQ-015 SHALL have port commit_pend  out  1  high while a commit is pending.

Function
REQ-016 Each channel SHALL hold active fword (ACC_W), pword (ADDR_W, the low cfg_wdata bits), and mode (2 bits: 0 saw, 1 triangle, 2 sine, 3 square), plus shadow copies of each.
REQ-017 cfg_we SHALL write cfg_wdata into the shadow register selected by cfg_ch/cfg_sel in the same cycle; cfg_ch >= N_CH or cfg_sel == 3 SHALL be ignored.
REQ-018 cfg_commit SHALL set commit_pend; at the next cycle with sample_en=1, all channels' shadows SHALL copy to active atomically and commit_pend SHALL clear.
REQ-019 cfg_commit coinciding with sample_en SHALL commit in that same cycle; the accumulate in that cycle uses the old fword.
REQ-020 A cfg_we coinciding with the commit cycle SHALL land in the shadow and SHALL be included in the commit.
REQ-021 On sample_en, acc[k] <= acc[k] + fword[k] modulo 2^ACC_W, and wrap[k] SHALL pulse in the following cycle when the addition carried out.
REQ-022 ph_clr[k] SHALL force acc[k] to 0 on that cycle and takes priority over accumulation; wrap[k] SHALL not pulse.
REQ-023 step_up[k]/step_dn[k] SHALL add/subtract FSTEP to the active fword[k], saturating at 2^ACC_W-1 and at 0; simultaneous up and dn SHALL be a no-op; a commit in the same cycle SHALL win.
REQ-024 Table address SHALL be acc[ACC_W-1 -: ADDR_W] + pword, modulo 2^ADDR_W.
REQ-025 Waveforms by phase address a: saw = a scaled to DATA_W; triangle = a MSB ? ~a<<1 : a<<1, scaled; square = a MSB ? 0 : all-ones; sine from lookup table.
REQ-026 Latency SHALL be fixed at 2 cycles: sample_en at cycle T -> updated wave_out and wave_valid pulse at T+2, for every mode.
REQ-027 Outputs SHALL hold between wave_valid pulses; back-to-back sample_en SHALL produce back-to-back valid samples.

Reset
REQ-028 rst SHALL asynchronously clear all accumulators, active and shadow fword to 0, pword to 0, and mode to 0 (saw).
REQ-029 During and after reset, wave_out SHALL be 0, and wave_valid, wrap, and commit_pend SHALL be 0; a pending commit SHALL be discarded.

Structure
REQ-030 A shared package SHALL hold the mode enumeration (SAW, TRI, SINE, SQR) and cfg_sel encodings.
REQ-031 The sine table SHALL be a sub-module dds_sine_lut: quarter-wave, registered output, 1-cycle latency, with 2^ADDR_W-entry equivalent; one instance per channel.
REQ-032 Non-sine modes SHALL be pipelined to match the LUT delay.

Verification
REQ-033 N_CH=4 reset then fword[0]=2^24 committed, sample_en every cycle -> saw ramps 0,1,2.. per sample; wrap[0] pulses every 256 samples.
REQ-034 Ch1 sine with pword=64 versus ch0 sine with pword=0, same fword -> ch1 leads ch0 by exactly a quarter period (64 samples at step 1).
REQ-035 Write fword for all 4 channels without commit -> outputs unchanged; commit with sample_en held low for 10 cycles -> commit_pend high 10 cycles, then all channels change on the same sample.
REQ-036 fword=2^32-100, step_up -> fword saturates at 2^32-1; fword=100, step_dn -> 0; step_up with step_dn together -> unchanged.
REQ-037 ph_clr[2] mid-run -> acc[2]=0 and next sample equals table[pword[2]]; other channels are unaffected.
REQ-038 Assert rst mid-stream asynchronously -> wave_out=0 immediately, commit_pend cleared, and mode reverts to saw after release.

Source files
------------

// File: rtl/dds_multi_gen_pkg.sv
// rtl/dds_multi_gen_pkg.sv - shared mode/select encodings and sine table generator
package dds_multi_gen_pkg;

    typedef enum logic [1:0] {
        SAW  = 2'd0,
        TRI  = 2'd1,
        SINE = 2'd2,
        SQR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SEL_FWORD = 2'd0,
        SEL_PWORD = 2'd1,
        SEL_MODE  = 2'd2,
        SEL_NONE  = 2'd3
    } cfg_sel_e;

    localparam longint PI_FX = 64'sd843314857;
    localparam int     FX_SH = 28;

    // round(amp * sin(pi/2 * idx / quarter)) via fixed-point Taylor series, elaboration-time only
    function automatic int quarter_sine(input int idx, input int quarter, input int amp);
        longint one;
        longint x;
        longint term;
        longint sum;
        one  = longint'(1) << FX_SH;
        x    = (PI_FX * idx) / (2 * quarter);
        term = x;
        sum  = x;
        for (int k = 1; k <= 6; k++) begin
            term = (term * x) / one;
            term = (term * x) / one;
            term = -(term / (2 * k * (2 * k + 1)));
            sum  = sum + term;
        end
        return int'((sum * amp + one / 2) / one);
    endfunction

endpackage

// File: rtl/dds_multi_gen_sine_lut.sv
// rtl/dds_multi_gen_sine_lut.sv - quarter-wave sine table with registered, enabled output
module dds_sine_lut
    import dds_multi_gen_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_q
);

    localparam int QTR = 1 << (ADDR_W - 2);
    localparam int AMP = (1 << (DATA_W - 1)) - 1;
    localparam logic [DATA_W-1:0] MID = DATA_W'(AMP + 1);

    // QTR+1 entries so the peak at the quadrant boundary is stored exactly
    logic [DATA_W-1:0] rom [QTR+1];
    logic [1:0]        quad;
    logic [ADDR_W-3:0] idx;
    logic [ADDR_W-2:0] ridx;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] data_d;

    for (genvar i = 0; i <= QTR; i++) begin : g_rom
        localparam int V = quarter_sine(i, QTR, AMP);
        assign rom[i] = DATA_W'(V);
    end

    always_comb begin
        quad   = addr[ADDR_W-1 -: 2];
        idx    = addr[ADDR_W-3:0];
        ridx   = quad[0] ? ((ADDR_W-1)'(QTR) - {1'b0, idx}) : {1'b0, idx};
        mag    = rom[ridx];
        data_d = data_q;
        if (en) begin
            data_d = quad[1] ? (MID - mag) : (MID + mag);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/dds_multi_gen.sv
// rtl/dds_multi_gen.sv - multi-channel DDS with shadowed config, atomic commit and 2-cycle output pipe
module dds_multi_gen
    import dds_multi_gen_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int FSTEP  = 300,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_en,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [1:0]               cfg_sel,
    input  logic [ACC_W-1:0]         cfg_wdata,
    input  logic                     cfg_commit,
    input  logic [N_CH-1:0]          step_up,
    input  logic [N_CH-1:0]          step_dn,
    input  logic [N_CH-1:0]          ph_clr,
    output logic [N_CH*DATA_W-1:0]   wave_out,
    output logic                     wave_valid,
    output logic [N_CH-1:0]          wrap,
    output logic                     commit_pend
);

    logic              commit_now;
    logic              pend_q, pend_d;
    logic              v1_q, v1_d, v2_q, v2_d;
    logic [N_CH-1:0]   wrap_q, wrap_d;

    logic [ACC_W-1:0]  acc_q [N_CH], acc_d [N_CH];
    logic [ACC_W:0]    acc_sum [N_CH];
    logic [ACC_W-1:0]  fword_q [N_CH], fword_d [N_CH];
    logic [ACC_W-1:0]  sh_fword_q [N_CH], sh_fword_d [N_CH];
    logic [ADDR_W-1:0] pword_q [N_CH], pword_d [N_CH];
    logic [ADDR_W-1:0] sh_pword_q [N_CH], sh_pword_d [N_CH];
    logic [ADDR_W-1:0] addr [N_CH];
    mode_e             mode_q [N_CH], mode_d [N_CH];
    mode_e             sh_mode_q [N_CH], sh_mode_d [N_CH];
    mode_e             st_mode_q [N_CH], st_mode_d [N_CH];
    logic [DATA_W-1:0] st_wave_q [N_CH], st_wave_d [N_CH];
    logic [N_CH-1:0][DATA_W-1:0] lut_q;

    // Left-justify the phase into the sample width (truncates or zero-extends)
    function automatic logic [DATA_W-1:0] scale(input logic [ADDR_W-1:0] a);
        logic [ADDR_W+DATA_W-1:0] wide;
        wide = {a, {DATA_W{1'b0}}};
        return wide[ADDR_W+DATA_W-1 -: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] shape(input mode_e m, input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] tri_a;
        tri_a = a[ADDR_W-1] ? {~a[ADDR_W-2:0], 1'b0} : {a[ADDR_W-2:0], 1'b0};
        case (m)
            TRI:     return scale(tri_a);
            SQR:     return a[ADDR_W-1] ? '0 : '1;
            default: return scale(a);
        endcase
    endfunction

    function automatic logic [ACC_W-1:0] step_fword(input logic [ACC_W-1:0] f,
                                                    input logic up, input logic dn);
        logic [ACC_W:0]   s;
        logic [ACC_W-1:0] r;
        s = {1'b0, f} + (ACC_W+1)'(FSTEP);
        r = f;
        if (up && !dn) begin
            r = s[ACC_W] ? '1 : s[ACC_W-1:0];
        end else if (dn && !up) begin
            r = (f < ACC_W'(FSTEP)) ? '0 : (f - ACC_W'(FSTEP));
        end
        return r;
    endfunction

    always_comb begin
        commit_now = sample_en & (pend_q | cfg_commit);
        pend_d     = ~commit_now & (pend_q | cfg_commit);
        v1_d       = sample_en;
        v2_d       = v1_q;
        wrap_d     = '0;
        for (int k = 0; k < N_CH; k++) begin
            sh_fword_d[k] = sh_fword_q[k];
            sh_pword_d[k] = sh_pword_q[k];
            sh_mode_d[k]  = sh_mode_q[k];
            if (cfg_we && int'(cfg_ch) == k) begin
                case (cfg_sel)
                    SEL_FWORD: sh_fword_d[k] = cfg_wdata;
                    SEL_PWORD: sh_pword_d[k] = cfg_wdata[ADDR_W-1:0];
                    SEL_MODE:  sh_mode_d[k]  = mode_e'(cfg_wdata[1:0]);
                    default:   ;
                endcase
            end

            // accumulate with the pre-commit fword; clear overrides everything
            acc_sum[k] = {1'b0, acc_q[k]} + {1'b0, fword_q[k]};
            acc_d[k]   = acc_q[k];
            if (ph_clr[k]) begin
                acc_d[k] = '0;
            end else if (sample_en) begin
                acc_d[k]  = acc_sum[k][ACC_W-1:0];
                wrap_d[k] = acc_sum[k][ACC_W];
            end

            pword_d[k] = pword_q[k];
            mode_d[k]  = mode_q[k];
            if (commit_now) begin
                fword_d[k] = sh_fword_d[k];
                pword_d[k] = sh_pword_d[k];
                mode_d[k]  = sh_mode_d[k];
            end else begin
                fword_d[k] = step_fword(fword_q[k], step_up[k], step_dn[k]);
            end

            addr[k]      = acc_q[k][ACC_W-1 -: ADDR_W] + pword_q[k];
            st_wave_d[k] = v1_q ? shape(mode_q[k], addr[k]) : st_wave_q[k];
            st_mode_d[k] = v1_q ? mode_q[k] : st_mode_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            wrap_q     <= '0;
            acc_q      <= '{default: '0};
            fword_q    <= '{default: '0};
            sh_fword_q <= '{default: '0};
            pword_q    <= '{default: '0};
            sh_pword_q <= '{default: '0};
            mode_q     <= '{default: SAW};
            sh_mode_q  <= '{default: SAW};
            st_mode_q  <= '{default: SAW};
            st_wave_q  <= '{default: '0};
        end else begin
            pend_q     <= pend_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            wrap_q     <= wrap_d;
            acc_q      <= acc_d;
            fword_q    <= fword_d;
            sh_fword_q <= sh_fword_d;
            pword_q    <= pword_d;
            sh_pword_q <= sh_pword_d;
            mode_q     <= mode_d;
            sh_mode_q  <= sh_mode_d;
            st_mode_q  <= st_mode_d;
            st_wave_q  <= st_wave_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        dds_sine_lut #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_lut (
            .clk    (clk),
            .rst    (rst),
            .en     (v1_q),
            .addr   (addr[k]),
            .data_q (lut_q[k])
        );
        assign wave_out[k*DATA_W +: DATA_W] = (st_mode_q[k] == SINE) ? lut_q[k] : st_wave_q[k];
    end

    assign wave_valid  = v2_q;
    assign wrap        = wrap_q;
    assign commit_pend = pend_q;

endmodule

// File: tb/tb_dds_multi_gen.sv
// tb/tb_dds_multi_gen.sv - self-checking bench for dds_multi_gen against a behavioural model
module tb_dds_multi_gen;

    localparam longint TWO32 = 64'd4294967296;
    localparam longint TWO24 = 64'd16777216;

    logic        clk = 1'b0;
    logic        rst, sample_en, cfg_we, cfg_commit;
    logic [1:0]  cfg_ch, cfg_sel;
    logic [31:0] cfg_wdata;
    logic [3:0]  step_up, step_dn, ph_clr;
    logic [31:0] wave_out;
    logic        wave_valid, commit_pend;
    logic [3:0]  wrap;

    int checks = 0;
    int errors = 0;

    longint m_acc [4], m_fw [4], m_sfw [4];
    int     m_pw [4], m_spw [4], m_md [4], m_smd [4];
    bit     m_pend, pipe_v, exp_valid;
    int     pipe_wave [4], exp_wave [4];
    bit     pipe_sine [4], exp_sine [4];
    bit [3:0] exp_wrap;

    typedef struct { int mode; int pw; int want; } vec_t;

    dds_multi_gen dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
        .step_up(step_up), .step_dn(step_dn), .ph_clr(ph_clr), .wave_out(wave_out),
        .wave_valid(wave_valid), .wrap(wrap), .commit_pend(commit_pend)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input longint act, input longint want, input int tol);
        checks++;
        if (act > want + tol || act < want - tol) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, want);
        end
    endfunction

    function automatic int ref_wave(input int m, input int a);
        real r;
        case (m)
            0: return a;
            1: return (a >= 128) ? 2 * (255 - a) : 2 * a;
            3: return (a >= 128) ? 0 : 255;
            default: begin
                r = 127.0 * $sin(2.0 * 3.14159265358979 * a / 256.0);
                return 128 + $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
            end
        endcase
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0; m_fw[k] = 0; m_sfw[k] = 0; m_pw[k] = 0; m_spw[k] = 0;
            m_md[k] = 0; m_smd[k] = 0; pipe_wave[k] = 0; exp_wave[k] = 0;
            pipe_sine[k] = 0; exp_sine[k] = 0;
        end
        m_pend = 0; pipe_v = 0; exp_valid = 0; exp_wrap = '0;
    endfunction

    function automatic void model_step();
        bit     do_commit;
        longint s;
        if (cfg_we) begin
            case (cfg_sel)
                2'd0: m_sfw[cfg_ch] = cfg_wdata;
                2'd1: m_spw[cfg_ch] = cfg_wdata % 256;
                2'd2: m_smd[cfg_ch] = cfg_wdata % 4;
                default: ;
            endcase
        end
        do_commit = sample_en && (m_pend || cfg_commit);
        m_pend    = !do_commit && (m_pend || cfg_commit);
        exp_valid = pipe_v;
        if (pipe_v) begin
            exp_wave = pipe_wave;
            exp_sine = pipe_sine;
        end
        for (int k = 0; k < 4; k++) begin
            exp_wrap[k] = 1'b0;
            if (ph_clr[k]) begin
                m_acc[k] = 0;
            end else if (sample_en) begin
                s = m_acc[k] + m_fw[k];
                exp_wrap[k] = (s >= TWO32);
                m_acc[k] = s % TWO32;
            end
            if (do_commit) begin
                m_fw[k] = m_sfw[k]; m_pw[k] = m_spw[k]; m_md[k] = m_smd[k];
            end else if (step_up[k] && !step_dn[k]) begin
                m_fw[k] = (m_fw[k] + 300 > TWO32 - 1) ? TWO32 - 1 : m_fw[k] + 300;
            end else if (step_dn[k] && !step_up[k]) begin
                m_fw[k] = (m_fw[k] < 300) ? 0 : m_fw[k] - 300;
            end
            if (sample_en) begin
                pipe_wave[k] = ref_wave(m_md[k], int'((m_acc[k] / TWO24 + m_pw[k]) % 256));
                pipe_sine[k] = (m_md[k] == 2);
            end
        end
        pipe_v = sample_en;
    endfunction

    function automatic void check_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wave%0d", k), wave_out[k*8 +: 8], exp_wave[k], exp_sine[k] ? 1 : 0);
            chk($sformatf("wrap%0d", k), wrap[k], exp_wrap[k], 0);
        end
        chk("wave_valid", wave_valid, exp_valid, 0);
        chk("commit_pend", commit_pend, m_pend, 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int sel, input longint val);
        cfg_we = 1'b1; cfg_ch = ch[1:0]; cfg_sel = sel[1:0]; cfg_wdata = val[31:0];
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic commit_with_sample();
        sample_en = 1'b1; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0; sample_en = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] up, input logic [3:0] dn, input logic [3:0] clr, input logic se);
        step_up = up; step_dn = dn; ph_clr = clr; sample_en = se;
        tick();
        step_up = '0; step_dn = '0; ph_clr = '0; sample_en = 1'b0;
    endtask

    initial begin
        vec_t vecs [17];
        int   s0 [200], s1 [200];
        int   nwrap;
        vecs = '{'{0, 0, 0}, '{0, 37, 37}, '{0, 255, 255},
                 '{1, 0, 0}, '{1, 100, 200}, '{1, 127, 254}, '{1, 128, 254}, '{1, 200, 110}, '{1, 255, 0},
                 '{3, 10, 255}, '{3, 128, 0},
                 '{2, 0, 128}, '{2, 64, 255}, '{2, 128, 128}, '{2, 192, 1}, '{2, 32, 218}, '{2, 224, 38}};
        sample_en = 0; cfg_we = 0; cfg_commit = 0; cfg_ch = 0; cfg_sel = 0; cfg_wdata = 0;
        step_up = 0; step_dn = 0; ph_clr = 0;
        do_reset();

        // waveform shapes at fixed phase (fword 0, acc 0, address = pword)
        for (int i = 0; i < 17; i++) begin
            cfg_write(0, 1, vecs[i].pw);
            cfg_write(0, 2, vecs[i].mode);
            commit_with_sample();
            tick();
            chk($sformatf("vec%0d", i), wave_out[7:0], vecs[i].want, 0);
        end

        // saw ramp on ch0 and wrap every 256 samples
        do_reset();
        cfg_write(0, 0, TWO24);
        commit_with_sample();
        sample_en = 1'b1;
        nwrap = 0;
        for (int i = 1; i <= 600; i++) begin
            tick();
            nwrap += int'(wrap[0]);
            if (i == 10 || i == 300) chk("saw_ramp", wave_out[7:0], (i - 1) % 256, 0);
        end
        chk("wrap_count", nwrap, 2, 0);

        // quarter-period lead of ch1 (pword 64) over ch0, both sine
        do_reset();
        for (int c = 0; c < 2; c++) begin
            cfg_write(c, 0, TWO24);
            cfg_write(c, 1, c * 64);
            cfg_write(c, 2, 2);
        end
        commit_with_sample();
        sample_en = 1'b1;
        tick();
        for (int i = 0; i < 200; i++) begin
            tick();
            s0[i] = int'(wave_out[7:0]);
            s1[i] = int'(wave_out[15:8]);
        end
        for (int i = 0; i < 64; i += 4) chk($sformatf("lead%0d", i), s1[i], s0[i+64], 0);

        // shadow writes without commit, then a commit held pending for 10 cycles
        for (int c = 0; c < 4; c++) cfg_write(c, 0, (c + 1) * 4194304);
        for (int i = 0; i < 5; i++) tick();
        sample_en = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("pend_hold0", commit_pend, 1, 0);
        for (int i = 1; i < 10; i++) begin
            tick();
            chk("pend_hold", commit_pend, 1, 0);
        end
        sample_en = 1'b1;
        tick();
        chk("pend_clear", commit_pend, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        sample_en = 1'b0;

        // fword saturation and simultaneous up/dn on ch3
        do_reset();
        cfg_write(3, 0, TWO32 - 100);
        commit_with_sample();
        pulse(4'b1000, 4'b0000, 4'b0000, 1'b0);
        pulse(4'b0000, 4'b0000, 4'b1000, 1'b0);
        pulse(4'b0000, 4'b0000, 4'b0000, 1'b1);
        tick();
        chk("sat_up", wave_out[31:24], 255, 0);
        cfg_write(3, 0, 100);
        commit_with_sample();
        pulse(4'b0000, 4'b1000, 4'b0000, 1'b0);
        pulse(4'b0000, 4'b0000, 4'b1000, 1'b0);
        pulse(4'b0000, 4'b0000, 4'b0000, 1'b1);
        tick();
        chk("sat_dn", wave_out[31:24], 0, 0);
        cfg_write(3, 0, TWO24 - 150);
        commit_with_sample();
        pulse(4'b1000, 4'b1000, 4'b0000, 1'b0);
        pulse(4'b0000, 4'b0000, 4'b1000, 1'b0);
        pulse(4'b0000, 4'b0000, 4'b0000, 1'b1);
        tick();
        chk("up_dn_noop", wave_out[31:24], 0, 0);

        // ph_clr on ch2 mid-run
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cfg_write(c, 0, TWO24);
            cfg_write(c, 1, (c == 2) ? 40 : c * 10);
        end
        commit_with_sample();
        sample_en = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        ph_clr = 4'b0100;
        tick();
        ph_clr = 4'b0000;
        tick();
        chk("clr_ch2", wave_out[23:16], 40, 0);

        // async reset mid-stream with a pending commit and sine output
        for (int c = 0; c < 4; c++) cfg_write(c, 2, 2);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        sample_en = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_wave", wave_out, 0, 0);
        chk("rst_pend", commit_pend, 0, 0);
        chk("rst_valid", wave_valid, 0, 0);
        tick();
        rst = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_mode_saw", wave_out[7:0], 0, 0);
        cfg_write(0, 0, TWO24);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_saw_ramp", wave_out[7:0], 5, 0);

        // randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            sample_en  = ($urandom_range(0, 1) == 1);
            cfg_we     = ($urandom_range(0, 3) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_sel    = 2'($urandom_range(0, 3));
            cfg_wdata  = $urandom;
            cfg_commit = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < 4; k++) begin
                step_up[k] = ($urandom_range(0, 7) == 0);
                step_dn[k] = ($urandom_range(0, 7) == 0);
                ph_clr[k]  = ($urandom_range(0, 31) == 0);
            end
            tick();
        end
        sample_en = 0; cfg_we = 0; cfg_commit = 0; step_up = 0; step_dn = 0; ph_clr = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
